pipelined_add_sub: RTL



---
 rtl/add_sub_pkg.sv | 22 ++
 rtl/pipelined_add_sub_if.sv | 31 +++
 rtl/add_sub_stage.sv | 42 ++++
 rtl/pipelined_add_sub.sv | 120 ++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and helpers for the pipelined adder/subtractor.
// Latency: none (compile-time definitions only).
// Backpressure: not applicable.
package add_sub_pkg;

  // Registered per-stage state handed from one chunk to the next.
  typedef struct packed {
    logic vld;
    logic cy;
  } stage_cv_t;

  // The width must split evenly into 1..width chunks.
  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Width of one pipeline chunk.
  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipelined_add_sub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
// Latency: none (wires only).
// Backpressure: valid/ready on both the operand and the result side.
interface pipelined_add_sub_if #(
  parameter int WIDTH = 32
) ();
  logic             In_Valid;
  logic             In_Ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Overflow;
  logic             Zero;

  // Producer/consumer side.
  modport master (
    output In_Valid, A, B, Cin, Sub, Out_Ready,
    input  In_Ready, Out_Valid, Sum, Cout, Overflow, Zero
  );

  // Arithmetic block side.
  modport slave (
    input  In_Valid, A, B, Cin, Sub, Out_Ready,
    output In_Ready, Out_Valid, Sum, Cout, Overflow, Zero
  );
endinterface

// File: rtl/add_sub_stage.sv
// One CW-bit chunk of the adder: adds a chunk plus carry-in, registers sum, carry, valid.
// Latency: 1 cycle when i_en is high.
// Backpressure: all registers hold while i_en is low.
module add_sub_stage
  import add_sub_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          i_en,
  input  logic          i_vld,
  input  logic          i_cin,
  input  logic [CW-1:0] i_a,
  input  logic [CW-1:0] i_b,
  output logic [CW-1:0] o_sum_nxt,
  output logic [CW-1:0] o_sum,
  output stage_cv_t     o_cv
);

  logic [CW:0]   w_add;
  logic [CW-1:0] r_sum;
  stage_cv_t     r_cv;

  assign w_add     = {1'b0, i_a} + {1'b0, i_b} + (CW+1)'(i_cin);
  assign o_sum_nxt = w_add[CW-1:0];
  assign o_sum     = r_sum;
  assign o_cv      = r_cv;

  // Capture the chunk result, its carry-out and the valid flag on each advance.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sum <= '0;
      r_cv  <= '0;
    end else if (i_en) begin
      r_sum  <= w_add[CW-1:0];
      r_cv.vld <= i_vld;
      r_cv.cy  <= w_add[CW];
    end
  end

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit add/subtract, one CW-bit chunk per stage with a registered carry chain.
// Latency: exactly STAGES cycles from accept to Out_Valid; one result per clock.
// Backpressure: a single advance enable; the whole pipe freezes while the result is unconsumed.
module pipelined_add_sub
  import add_sub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic                 Clk,
  input logic                 Rst,
  pipelined_add_sub_if.slave  bus
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_param_err
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic             w_adv;
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [WIDTH-1:0] w_lo_in [STAGES+1];
  logic [CW-1:0]    w_chunk     [STAGES];
  logic [CW-1:0]    w_chunk_nxt [STAGES];
  stage_cv_t        w_cv    [STAGES];

  logic [WIDTH-1:0] w_res_nxt;
  logic             w_ovf_nxt;
  logic             w_zero_nxt;
  logic             r_ovf;
  logic             r_zero;

  // The pipe moves whenever the output slot is empty or being drained.
  assign w_adv        = !w_cv[STAGES-1].vld || bus.Out_Ready;
  assign bus.In_Ready = w_adv;

  // Stage 0 sees the raw operands; subtract is add of the inverted B with inverted carry-in.
  assign w_a_in[0]  = bus.A;
  assign w_b_in[0]  = bus.B ^ {WIDTH{bus.Sub}};
  assign w_c_in[0]  = bus.Cin ^ bus.Sub;
  assign w_v_in[0]  = bus.In_Valid;
  assign w_lo_in[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] r_lo;

    add_sub_stage #(.CW(CW)) u_stage (
      .Clk       (Clk),
      .Rst       (Rst),
      .i_en      (w_adv),
      .i_vld     (w_v_in[k]),
      .i_cin     (w_c_in[k]),
      .i_a       (w_a_in[k][k*CW +: CW]),
      .i_b       (w_b_in[k][k*CW +: CW]),
      .o_sum_nxt (w_chunk_nxt[k]),
      .o_sum     (w_chunk[k]),
      .o_cv      (w_cv[k])
    );

    // Deskew: lower sum chunks already finished travel alongside this stage.
    always_ff @(posedge Clk) begin
      if (Rst) begin
        r_lo <= '0;
      end else if (w_adv) begin
        r_lo <= w_lo_in[k];
      end
    end

    assign w_lo_in[k+1] = r_lo | (WIDTH'(w_chunk[k]) << (k*CW));

    if (k < STAGES-1) begin : g_skew
      logic [WIDTH-1:0] r_a;
      logic [WIDTH-1:0] r_b;

      // Skew: operand chunks not yet consumed follow the carry down the pipe.
      always_ff @(posedge Clk) begin
        if (Rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a_in[k];
          r_b <= w_b_in[k];
        end
      end

      assign w_a_in[k+1] = r_a;
      assign w_b_in[k+1] = r_b;
      assign w_c_in[k+1] = w_cv[k].cy;
      assign w_v_in[k+1] = w_cv[k].vld;
    end
  end

  // Full result as it will be registered by the final stage.
  assign w_res_nxt  = w_lo_in[STAGES-1] | (WIDTH'(w_chunk_nxt[STAGES-1]) << ((STAGES-1)*CW));
  assign w_ovf_nxt  = (w_a_in[STAGES-1][WIDTH-1] == w_b_in[STAGES-1][WIDTH-1]) &&
                      (w_res_nxt[WIDTH-1] != w_a_in[STAGES-1][WIDTH-1]);
  assign w_zero_nxt = (w_res_nxt == '0);

  // Flags are registered alongside the final sum chunk; bubbles leave them low.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_ovf  <= w_v_in[STAGES-1] && w_ovf_nxt;
      r_zero <= w_v_in[STAGES-1] && w_zero_nxt;
    end
  end

  assign bus.Out_Valid = w_cv[STAGES-1].vld;
  assign bus.Sum       = w_lo_in[STAGES];
  assign bus.Cout      = w_cv[STAGES-1].cy;
  assign bus.Overflow  = r_ovf;
  assign bus.Zero      = r_zero;

endmodule
